// File: rtl/contador_controlador_pkg.sv
// Shared types and defaults for the contador_controlador run controller.
// Holds the FSM state encoding and the default counter / wrap widths.
package contador_controlador_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/contador_controlador_if.sv
// Control/status bundle between the register logic (master) and the run controller (slave).
// The counter-facing signals (count_i, cnt_en, cnt_clr) travel on the same bundle.
interface contador_controlador_if #(
  parameter int WIDTH  = contador_controlador_pkg::WIDTH_DEF,
  parameter int WRAP_W = contador_controlador_pkg::WRAP_W_DEF
);

  logic              start;
  logic              pause;
  logic              resume;
  logic              abort;
  logic              periodic;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  count_i;
  logic              cnt_en;
  logic              cnt_clr;
  logic              busy;
  logic              done;
  logic              err;
  logic [WRAP_W-1:0] wraps;
  logic              stall;

  modport slave (
    input  start, pause, resume, abort, periodic, limit, count_i,
    output cnt_en, cnt_clr, busy, done, err, wraps, stall
  );

  modport master (
    output start, pause, resume, abort, periodic, limit, count_i,
    input  cnt_en, cnt_clr, busy, done, err, wraps, stall
  );

endinterface

// File: rtl/contador_controlador.sv
// Run controller for a WIDTH-bit counter: clear, count to a latched limit, stop or repeat.
// Optional stuck-counter watchdog enabled by defining CONTADOR_CTRL_WATCHDOG_EN.
module contador_controlador
  import contador_controlador_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  contador_controlador_if.slave   bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic [WIDTH-1:0]  r_limit_q;
  logic              r_periodic_q;
  logic              r_done;
  logic              r_err;
  logic [WRAP_W-1:0] r_wraps;

  logic w_terminal;
  logic w_start_ok;
  logic w_start_bad;
  logic w_period_end;
  logic w_cnt_en;
  logic w_cnt_clr;
  logic w_busy;

  assign w_terminal   = (bus.count_i == r_limit_q);
  assign w_start_ok   = (r_state == ST_IDLE) && bus.start && !bus.abort && (bus.limit != '0);
  assign w_start_bad  = (r_state == ST_IDLE) && bus.start && !bus.abort && (bus.limit == '0);
  // Abort on the terminal cycle discards the period: no done, no wrap increment.
  assign w_period_end = (r_state == ST_RUN) && w_terminal && !bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of process ordering.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    if (bus.abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start_ok) w_next_state = ST_CLEAR;
        ST_CLEAR: w_next_state = ST_RUN;
        ST_RUN: begin
          if (w_terminal)     w_next_state = r_periodic_q ? ST_CLEAR : ST_DONE;
          else if (bus.pause) w_next_state = ST_PAUSE;
        end
        ST_PAUSE: if (bus.resume) w_next_state = ST_RUN;
        ST_DONE:  w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_en  = 1'b0;
    w_cnt_clr = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      ST_CLEAR: begin w_cnt_clr = 1'b1; w_busy = 1'b1; end
      ST_RUN:   begin w_cnt_en = !w_terminal; w_busy = 1'b1; end
      ST_PAUSE: w_busy = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_limit_q    <= '0;
      r_periodic_q <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_wraps      <= '0;
    end else begin
      r_done <= w_period_end;
      r_err  <= w_start_bad;
      if (w_start_ok) begin
        r_limit_q    <= bus.limit;
        r_periodic_q <= bus.periodic;
        r_wraps      <= '0;
      end else if (w_period_end) begin
        r_wraps <= r_wraps + WRAP_W'(1);
      end
    end
  end

`ifdef CONTADOR_CTRL_WATCHDOG_EN
  logic [WIDTH-1:0] r_prev_count;
  logic             r_prev_en;
  logic             r_stall;
  logic [WIDTH-1:0] w_prev_inc;

  assign w_prev_inc = r_prev_count + WIDTH'(1);

  // A cycle after enabling, the counter must have advanced by exactly one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_count <= '0;
      r_prev_en    <= 1'b0;
      r_stall      <= 1'b0;
    end else begin
      r_prev_count <= bus.count_i;
      r_prev_en    <= w_cnt_en;
      if (w_start_ok)
        r_stall <= 1'b0;
      else if ((r_state == ST_RUN) && r_prev_en && (bus.count_i != w_prev_inc))
        r_stall <= 1'b1;
    end
  end

  assign bus.stall = r_stall;
`else
  assign bus.stall = 1'b0;
`endif

  assign bus.cnt_en  = w_cnt_en;
  assign bus.cnt_clr = w_cnt_clr;
  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.wraps   = r_wraps;

endmodule

// File: tb/tb_contador_controlador.sv
// Scoreboard bench for contador_controlador paired with a behavioural 4-bit counter.
// Expected done/err pulses are queued by the stimulus and matched by an independent monitor.
module tb_contador_controlador;
  import contador_controlador_pkg::*;

  localparam int W  = 4;
  localparam int RW = 8;

`ifdef CONTADOR_CTRL_WATCHDOG_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stuck = 1'b0;
  logic [W-1:0] r_cnt;

  always #5 clk = ~clk;

  contador_controlador_if #(.WIDTH(W), .WRAP_W(RW)) bus ();

  contador_controlador #(.WIDTH(W), .WRAP_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Controlled counter: synchronous clear, enable, reset from the controller's reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (bus.cnt_clr)             r_cnt <= '0;
    else if (bus.cnt_en && !stuck)    r_cnt <= r_cnt + 4'd1;
  end
  assign bus.count_i = r_cnt;

  typedef struct {
    bit is_err;
    int wraps;
    int en;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   done_seen = 0;
  int   en_cnt    = 0;
  int   m_wraps   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done || bus.err) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, bus.done, bus.err}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind", bus.err, mon_e.is_err);
          check("pulse_wraps", bus.wraps, mon_e.wraps);
          if (!mon_e.is_err) begin
            check("en_cycles", en_cnt, mon_e.en);
            check("count_at_done", bus.count_i, mon_e.cnt);
          end
        end
        if (bus.done) done_seen++;
      end
      if (bus.cnt_clr)     en_cnt = 0;
      else if (bus.cnt_en) en_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int lim, input bit per);
    bus.limit    = W'(lim);
    bus.periodic = per;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (!bus.busy && sb.size() == 0) break;
      tick();
    end
    check({name, "_timeout"}, (i < 200), 1);
  endtask

  task automatic wait_count(input string name, input int val);
    int i;
    for (i = 0; i < 100; i++) begin
      if (bus.cnt_en && bus.count_i == W'(val)) break;
      tick();
    end
    check({name, "_reach"}, (i < 100), 1);
  endtask

  // One-shot run; pause_at < 0 means no pause, ign asks for an ignored mid-run start.
  task automatic run_oneshot(input int lim, input int pause_at, input bit ign);
    int k;
    m_wraps = 1;
    sb.push_back('{is_err: 1'b0, wraps: 1, en: lim, cnt: lim});
    pulse_start(lim, 1'b0);
    check("clr_first", bus.cnt_clr, 1);
    check("busy_clear", bus.busy, 1);
    tick();
    check("clr_one_cycle", bus.cnt_clr, 0);
    if (ign) pulse_start((lim == 15) ? 14 : 15, 1'b1);
    if (pause_at >= 0) begin
      wait_count("pause", pause_at);
      bus.pause = 1'b1;
      tick();
      bus.pause = 1'b0;
      k = $urandom_range(1, 4);
      repeat (k) begin
        check("pause_hold", bus.count_i, pause_at + 1);
        check("pause_en", bus.cnt_en, 0);
        check("pause_busy", bus.busy, 1);
        tick();
      end
      bus.resume = 1'b1;
      tick();
      bus.resume = 1'b0;
    end
    wait_idle("oneshot");
    check("oneshot_wraps", bus.wraps, m_wraps);
    check("oneshot_final_count", bus.count_i, lim);
    check("oneshot_stall", bus.stall, 0);
  endtask

  task automatic run_periodic(input int lim, input int periods);
    int i;
    int base;
    int c;
    for (int p = 1; p <= periods; p++)
      sb.push_back('{is_err: 1'b0, wraps: p, en: lim, cnt: lim});
    base = done_seen;
    pulse_start(lim, 1'b1);
    for (i = 0; i < 400; i++) begin
      if (done_seen - base >= periods) break;
      tick();
    end
    check("periodic_timeout", (i < 400), 1);
    pulse_abort();
    m_wraps = periods;
    check("abort_busy", bus.busy, 0);
    check("abort_en", bus.cnt_en, 0);
    c = int'(bus.count_i);
    tick(3);
    check("abort_count_hold", bus.count_i, c);
    check("abort_wraps_held", bus.wraps, m_wraps);
    check("periodic_sb_empty", sb.size(), 0);
    check("periodic_stall", bus.stall, 0);
  endtask

  // Abort lands on the terminal cycle: period is discarded, no done pulse.
  task automatic run_abort_terminal(input int lim);
    m_wraps = 0;
    pulse_start(lim, 1'b0);
    tick();
    wait_count("abort_term", lim - 1);
    tick();
    check("term_en_low", bus.cnt_en, 0);
    check("term_count", bus.count_i, lim);
    pulse_abort();
    tick(3);
    check("term_busy", bus.busy, 0);
    check("term_wraps", bus.wraps, 0);
    check("term_state", dut.r_state, ST_IDLE);
  endtask

  task automatic run_err();
    sb.push_back('{is_err: 1'b1, wraps: m_wraps, en: 0, cnt: 0});
    pulse_start(0, 1'($urandom_range(0, 1)));
    check("err_no_clr", bus.cnt_clr, 0);
    check("err_busy", bus.busy, 0);
    tick();
    check("err_one_cycle", bus.err, 0);
    check("err_busy_after", bus.busy, 0);
    wait_idle("err");
  endtask

  task automatic run_watchdog();
    stuck = 1'b0;
    pulse_start(12, 1'b0);
    tick();
    wait_count("wd", 2);
    stuck = 1'b1;
    tick(2);
    check("wd_stall_set", bus.stall, WD_ON);
    pulse_abort();
    stuck = 1'b0;
    tick(2);
    check("wd_stall_sticky", bus.stall, WD_ON);
    m_wraps = 1;
    sb.push_back('{is_err: 1'b0, wraps: 1, en: 3, cnt: 3});
    pulse_start(3, 1'b0);
    check("wd_stall_cleared", bus.stall, 0);
    wait_idle("wd_rerun");
  endtask

  task automatic run_midreset();
    pulse_start(10, 1'b1);
    tick(4);
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_en", bus.cnt_en, 0);
    check("rst_clr", bus.cnt_clr, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_wraps", bus.wraps, 0);
    check("rst_stall", bus.stall, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    m_wraps = 0;
    tick(2);
    check("rst_state", dut.r_state, ST_IDLE);
  endtask

  initial begin
    int sel;
    int lim;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.resume   = 1'b0;
    bus.abort    = 1'b0;
    bus.periodic = 1'b0;
    bus.limit    = '0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_en", bus.cnt_en, 0);
    check("reset_clr", bus.cnt_clr, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_wraps", bus.wraps, 0);
    check("reset_stall", bus.stall, 0);
    check("reset_state", dut.r_state, ST_IDLE);
    tick();

    run_oneshot(5, -1, 1'b0);
    run_periodic(3, 4);
    run_oneshot(5, 2, 1'b0);
    run_err();
    run_oneshot(1, -1, 1'b1);
    run_abort_terminal(15);
    run_periodic(1, 3);

    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 4);
      lim = $urandom_range(1, 15);
      case (sel)
        0: run_oneshot(lim, -1, 1'($urandom_range(0, 1)));
        1: run_oneshot(lim, $urandom_range(0, lim - 1), 1'b0);
        2: run_periodic(lim, $urandom_range(1, 4));
        3: run_abort_terminal(lim);
        default: run_err();
      endcase
    end

    run_watchdog();
    run_midreset();
    run_oneshot(7, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

endmodule
